// File: rtl/register_pkg.sv
// Shared constants and sizing helpers for the register bank and its entries.
package register_pkg;

   localparam int unsigned REG_RESET_VAL = 0;

   // Byte lanes in a data word.
   function automatic int lane_count(input int width);
      return width / 8;
   endfunction

   // Address width, never narrower than one bit so a two-entry bank still has an address.
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/register_bank_if.sv
// Write port plus two read ports of the register bank, grouped for the decode and write-back stages.
interface register_bank_if
   import register_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   localparam int AW = addr_width(DEPTH);
   localparam int NB = lane_count(WIDTH);

   logic             write_enable;
   logic [AW-1:0]    write_addr;
   logic [NB-1:0]    byte_en;
   logic [WIDTH-1:0] data_in;
   logic [AW-1:0]    read_addr_a;
   logic [WIDTH-1:0] data_out_a;
   logic [AW-1:0]    read_addr_b;
   logic [WIDTH-1:0] data_out_b;

   modport master (
      output write_enable, write_addr, byte_en, data_in, read_addr_a, read_addr_b,
      input  data_out_a, data_out_b
   );

   modport slave (
      input  write_enable, write_addr, byte_en, data_in, read_addr_a, read_addr_b,
      output data_out_a, data_out_b
   );
endinterface

// File: rtl/register_entry.sv
// One register word with per-byte-lane write enables and asynchronous clear.
module register_entry
   import register_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [lane_count(WIDTH)-1:0] lane_we,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             data_out
);
   localparam int NB = lane_count(WIDTH);

   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   // NOTE: assign a default first so every path drives word_d and no latch is inferred.
   always_comb begin
      word_d = word_q;
      for (int l = 0; l < NB; l++) begin
         if (lane_we[l]) word_d[8*l +: 8] = data_in[8*l +: 8];
      end
   end

   // NOTE: this storage is reset because the register file must read all-zero straight out of reset;
   // sequential state uses non-blocking assignments so all entries update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) word_q <= WIDTH'(REG_RESET_VAL);
      else       word_q <= word_d;
   end

   assign data_out = word_q;
endmodule

// File: rtl/register_bank.sv
// Multi-entry register bank: byte-lane writes, two combinational read ports, optional write bypass.
module register_bank
   import register_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic           clk,
   input logic           reset,
   register_bank_if.slave bus
);
   localparam int NB = lane_count(WIDTH);
   localparam int AW = addr_width(DEPTH);

   logic [WIDTH-1:0] rd_word [DEPTH];
   logic             wr_valid;
   logic             wr_bypass;

   assign wr_valid = bus.write_enable && !reset && (int'(bus.write_addr) < DEPTH);
   // Forwarding is never offered for the hardwired zero entry.
   assign wr_bypass = BYPASS && wr_valid && !(ZERO_REG && (bus.write_addr == '0));

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (ZERO_REG && (i == 0)) begin : g_zero
         assign rd_word[i] = WIDTH'(REG_RESET_VAL);
      end else begin : g_reg
         logic [NB-1:0] lane_we;
         assign lane_we = (wr_valid && (bus.write_addr == AW'(i))) ? bus.byte_en : '0;
         register_entry #(.WIDTH(WIDTH)) u_entry (
            .clk      (clk),
            .reset    (reset),
            .lane_we  (lane_we),
            .data_in  (bus.data_in),
            .data_out (rd_word[i])
         );
      end
   end

   logic [WIDTH-1:0] stored_a, stored_b;
   logic [WIDTH-1:0] out_a, out_b;
   logic             hit_a, hit_b;

   // Decoded mux: addresses at or beyond DEPTH match nothing and read as zero.
   always_comb begin
      stored_a = '0;
      stored_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.read_addr_a == AW'(i)) stored_a = rd_word[i];
         if (bus.read_addr_b == AW'(i)) stored_b = rd_word[i];
      end
   end

   always_comb begin
      hit_a = wr_bypass && (bus.read_addr_a == bus.write_addr);
      hit_b = wr_bypass && (bus.read_addr_b == bus.write_addr);
      out_a = stored_a;
      out_b = stored_b;
      for (int l = 0; l < NB; l++) begin
         if (hit_a && bus.byte_en[l]) out_a[8*l +: 8] = bus.data_in[8*l +: 8];
         if (hit_b && bus.byte_en[l]) out_b[8*l +: 8] = bus.data_in[8*l +: 8];
      end
   end

   assign bus.data_out_a = out_a;
   assign bus.data_out_b = out_b;
endmodule

// File: tb/tb_register_bank.sv
// Directed bench: default bank, a no-bypass bank and a six-entry bank driven with identical stimulus.
module tb_register_bank;
   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   register_bank_if #(.WIDTH(32), .DEPTH(8)) bus0 ();
   register_bank_if #(.WIDTH(32), .DEPTH(8)) bus1 ();
   register_bank_if #(.WIDTH(32), .DEPTH(6)) bus2 ();

   register_bank #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   register_bank #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));
   register_bank #(.WIDTH(32), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic we, input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
      bus0.write_enable = we; bus0.write_addr = a; bus0.byte_en = be; bus0.data_in = d;
      bus1.write_enable = we; bus1.write_addr = a; bus1.byte_en = be; bus1.data_in = d;
      bus2.write_enable = we; bus2.write_addr = a; bus2.byte_en = be; bus2.data_in = d;
   endtask

   task automatic rd(input logic [2:0] a, input logic [2:0] b);
      bus0.read_addr_a = a; bus0.read_addr_b = b;
      bus1.read_addr_a = a; bus1.read_addr_b = b;
      bus2.read_addr_a = a; bus2.read_addr_b = b;
   endtask

   task automatic step_mid();  // move to the middle of the low phase
      @(negedge clk);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      wr(1'b0, 3'd0, 4'h0, 32'h0);
      rd(3'd0, 3'd0);

      // Reset: every address on both ports reads zero
      for (int i = 0; i < 8; i++) begin
         step_mid();
         rd(3'(i), 3'(7 - i));
         #1;
         check($sformatf("rst_a%0d", i), bus0.data_out_a, 32'h0);
         check($sformatf("rst_b%0d", 7 - i), bus0.data_out_b, 32'h0);
      end

      step_mid();
      reset = 1'b0;
      wr(1'b1, 3'd3, 4'hF, 32'hA5A5A5A5);
      rd(3'd0, 3'd0);
      after_edge();
      step_mid();
      wr(1'b0, 3'd0, 4'h0, 32'h0);
      rd(3'd3, 3'd3);
      #1;
      check("wr3_a", bus0.data_out_a, 32'hA5A5A5A5);
      check("wr3_nobyp_b", bus1.data_out_b, 32'hA5A5A5A5);

      // Byte lanes on entry 5
      step_mid();
      wr(1'b1, 3'd5, 4'hF, 32'h11223344);
      after_edge();
      step_mid();
      wr(1'b1, 3'd5, 4'b0101, 32'hAABBCCDD);
      rd(3'd5, 3'd5);
      #1;
      check("lane_nobyp_pre", bus1.data_out_a, 32'h11223344);
      after_edge();
      step_mid();
      wr(1'b1, 3'd5, 4'b0000, 32'hFFFFFFFF);
      #1;
      check("lane_merge", bus1.data_out_a, 32'h11BB33DD);
      check("zero_strobe_byp", bus0.data_out_b, 32'h11BB33DD);
      after_edge();
      step_mid();
      wr(1'b0, 3'd0, 4'h0, 32'h0);
      #1;
      check("zero_strobe_kept", bus0.data_out_a, 32'h11BB33DD);

      // Bypass on entry 2
      step_mid();
      wr(1'b1, 3'd2, 4'hF, 32'h0000FFFF);
      after_edge();
      step_mid();
      wr(1'b1, 3'd2, 4'b1100, 32'h12345678);
      rd(3'd2, 3'd2);
      #1;
      check("byp_a", bus0.data_out_a, 32'h1234FFFF);
      check("byp_b", bus0.data_out_b, 32'h1234FFFF);
      check("nobyp_a", bus1.data_out_a, 32'h0000FFFF);
      check("nobyp_b", bus1.data_out_b, 32'h0000FFFF);
      after_edge();
      check("nobyp_post", bus1.data_out_a, 32'h1234FFFF);

      // Hardwired zero entry
      step_mid();
      wr(1'b1, 3'd0, 4'hF, 32'hDEADBEEF);
      rd(3'd0, 3'd0);
      #1;
      check("zero_wr_a", bus0.data_out_a, 32'h0);
      check("zero_wr_b", bus0.data_out_b, 32'h0);
      after_edge();
      check("zero_post_a", bus0.data_out_a, 32'h0);
      check("zero_post_b", bus1.data_out_b, 32'h0);

      // Out-of-range address on the six-entry bank; last valid entry on the eight-entry bank
      step_mid();
      wr(1'b1, 3'd7, 4'hF, 32'hCAFEF00D);
      rd(3'd7, 3'd7);
      #1;
      check("oor_wr_a", bus2.data_out_a, 32'h0);
      check("oor_wr_b", bus2.data_out_b, 32'h0);
      after_edge();
      step_mid();
      wr(1'b0, 3'd0, 4'h0, 32'h0);
      #1;
      check("oor_post_a", bus2.data_out_a, 32'h0);
      check("top_entry_d8", bus0.data_out_b, 32'hCAFEF00D);
      rd(3'd3, 3'd5);
      #1;
      check("oor_e3_kept", bus2.data_out_a, 32'hA5A5A5A5);
      check("oor_e5_kept", bus2.data_out_b, 32'h11BB33DD);

      // Fill entries with i+1, then reset asynchronously mid-cycle
      for (int i = 1; i < 8; i++) begin
         step_mid();
         wr(1'b1, 3'(i), 4'hF, 32'(i + 1));
         after_edge();
      end
      step_mid();
      wr(1'b0, 3'd0, 4'h0, 32'h0);
      rd(3'd7, 3'd4);
      #1;
      check("fill_a7", bus0.data_out_a, 32'd8);
      check("fill_b4", bus0.data_out_b, 32'd5);
      check("fill_d6_b4", bus2.data_out_b, 32'd5);

      step_mid();
      wr(1'b1, 3'd6, 4'hF, 32'h77777777);
      rd(3'd6, 3'd7);
      #1;
      check("pre_rst_byp", bus0.data_out_a, 32'h77777777);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_a", bus0.data_out_a, 32'h0);
      check("async_rst_b", bus0.data_out_b, 32'h0);
      after_edge();
      step_mid();
      reset = 1'b0;
      wr(1'b0, 3'd0, 4'h0, 32'h0);
      #1;
      check("rst_wr_lost", bus0.data_out_a, 32'h0);
      check("rst_clr_b", bus0.data_out_b, 32'h0);
      rd(3'd1, 3'd4);
      #1;
      check("rst_clr_e1", bus1.data_out_a, 32'h0);
      check("rst_clr_e4", bus2.data_out_b, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised multi-entry register bank. It generalises the single `register` block from one word to `DEPTH` words. Writes can update individual byte lanes, and two independent read ports are served in the same cycle with optional write-to-read bypass. It serves as the VeriRISC general-purpose register file: the decode stage drives both read ports and the write-back stage drives the write port.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits; must be a multiple of 8.
- `DEPTH`, 8: number of entries; ≥ 2, need not be a power of two.
- `ZERO_REG`, 1: when 1, entry 0 is hardwired to zero.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to the matching read port.

Ports (derived: `AW` = max(1, clog2(`DEPTH`)), `NB` = `WIDTH`/8):
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears every entry.
- `write_enable` input 1: commits a write at the rising edge when high.
- `write_addr` input `AW`: entry written.
- `byte_en` input `NB`: per-lane write strobe; bit i covers `data_in[8i+7:8i]`.
- `data_in` input `WIDTH`: write data.
- `read_addr_a` input `AW`: read port A address.
- `data_out_a` output `WIDTH`: read port A data, combinational.
- `read_addr_b` input `AW`: read port B address.
- `data_out_b` output `WIDTH`: read port B data, combinational.

## Operation
- **Reset.** While `reset` is high, all entries are 0 and writes are ignored. Both outputs read 0 regardless of address.
- **Write.** A write is effective when `write_enable` is high, `reset` is low and `write_addr` < `DEPTH`. On the rising edge, a lane is updated only where its `byte_en` bit is 1; other lanes keep their value.
- **Zero strobe.** `byte_en` = 0 with `write_enable` = 1 is legal and leaves the entry unchanged.
- **Zero register.** With `ZERO_REG` = 1, writes to address 0 are discarded and reads of address 0 return 0.
- **Out-of-range addresses.** Addresses ≥ `DEPTH` are ignored on write and return 0 on read.
- **Read.** Each read port combinationally returns the stored entry at its address. Ports are fully independent; both may address the same entry.
- **Bypass.** With `BYPASS` = 1, if a port's address equals `write_addr` and the write is effective, that port returns the merged value: `data_in` on enabled lanes, stored data on the rest.
  - Bypass is suppressed for address 0 when `ZERO_REG` = 1.
  - Bypass is suppressed while `reset` is high.
- **No bypass.** With `BYPASS` = 0, reads return the pre-edge contents; the new value appears after the write edge.

## Timing
- Write latency is 1 cycle: the value is visible on a non-bypassed read in the cycle after the write edge.
- Bypassed read latency is 0 cycles, through the same-cycle combinational path.
- `reset` asserted mid-cycle clears all entries immediately, without waiting for a clock edge. Outputs drop to 0 within the same cycle.
- `reset` deasserting in the same cycle as a write: the write takes effect at the next rising edge after deassertion if `write_enable` is still high.
- There are no handshakes or stalls; the bank accepts one write per cycle, back-to-back.
- Back-to-back writes to the same address: the last edge wins. Partial-lane writes accumulate across cycles.

## Structure
- Package `register_pkg` holds:
  - the `WIDTH`/8 lane-count helper function;
  - the address-width helper function (clog2 with minimum 1);
  - the reset value constant, `REG_RESET_VAL` = 0.
- Sub-module `register_entry` (params `WIDTH`):
  - one word with async active-high reset and a per-lane write enable;
  - instantiated `DEPTH` times, or `DEPTH`−1 times when `ZERO_REG` = 1.
- The top level contains the write-address decode, the two read multiplexers and the bypass merge logic.

## Test plan
1. **Reset.** Assert `reset`, sweep both read addresses 0..`DEPTH`−1 → both outputs 0. Deassert `reset`, write `32'hA5A5A5A5` to entry 3 with `byte_en` = `4'hF` → `data_out_a` at address 3 reads `32'hA5A5A5A5` the next cycle.
2. **Byte lanes.** Entry 5 holds `32'h11223344`. Write `32'hAABBCCDD` with `byte_en` = `4'b0101` → entry 5 = `32'h11BB33DD`. Then write with `byte_en` = 0 → unchanged.
3. **Bypass.** `BYPASS` = 1, entry 2 holds `32'h0000FFFF`. Write `32'h12345678`, `byte_en` = `4'b1100`, with `read_addr_a` = `read_addr_b` = 2 → both ports show `32'h1234FFFF` in the same cycle. Repeat with `BYPASS` = 0 → both show `32'h0000FFFF` until after the edge.
4. **Zero register.** `ZERO_REG` = 1: write `32'hDEADBEEF` to address 0 → reads of address 0 on both ports stay 0, including during the write cycle.
5. **Async reset mid-run.** Fill all entries with distinct values (entry i = i+1). Assert `reset` asynchronously between clock edges → both outputs 0 before the next edge. Writes issued during reset are lost.
6. **Non-power-of-two depth.** `DEPTH` = 6: write `32'hCAFEF00D` to address 7 → no entry changes, and address 7 reads 0 on both ports.
